// File: rtl/result_checker_if.sv
// Signal bundle for result_checker: Avalon-MM write port, two show-ahead FIFO read ports
// and the stimulus->checker command channel. master = checker side, slave = environment side.
interface result_checker_if #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RTF_WIDTH   = 24,
  parameter int unsigned CYCLE_RANGE = 5,
  parameter int unsigned SCC_WIDTH   = 5
);
  logic [ADDR_WIDTH-1:0]             mem_address;
  logic [DATA_WIDTH/8-1:0]           mem_byteenable;
  logic                              mem_write;
  logic [DATA_WIDTH-1:0]             mem_writedata;
  logic                              mem_waitrequest;
  logic [RTF_WIDTH+CYCLE_RANGE:0]    rfifo_data;
  logic                              rfifo_rdreq;
  logic                              rfifo_rdempty;
  logic [2*RTF_WIDTH+ADDR_WIDTH-1:0] cfifo_data;
  logic                              cfifo_rdreq;
  logic                              cfifo_rdempty;
  logic [SCC_WIDTH-1:0]              sc_cmd;
  logic [RTF_WIDTH-1:0]              sc_data;
  logic                              sc_ready;

  modport master (
    output mem_address, mem_byteenable, mem_write, mem_writedata,
    output rfifo_rdreq, cfifo_rdreq, sc_ready,
    input  mem_waitrequest, rfifo_data, rfifo_rdempty, cfifo_data, cfifo_rdempty,
    input  sc_cmd, sc_data
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_write, mem_writedata,
    input  rfifo_rdreq, cfifo_rdreq, sc_ready,
    output mem_waitrequest, rfifo_data, rfifo_rdempty, cfifo_data, cfifo_rdempty,
    output sc_cmd, sc_data
  );
endinterface

// File: rtl/result_checker.sv
// Result checker: pops one result and one expectation, compares under bitmask/don't-care and writes
// a RES_WORDS-word record over Avalon-MM. Define CHECK_STATS_EN for pass/fail counters.
module result_checker #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RTF_WIDTH   = 24,
  parameter int unsigned CYCLE_RANGE = 5,
  parameter int unsigned SCC_WIDTH   = 5
`ifdef CHECK_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH   = 16
`endif
) (
  input logic              clock,
  input logic              reset,
  result_checker_if.master bus
`ifdef CHECK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count
`endif
);
  localparam int unsigned META_WIDTH = CYCLE_RANGE + 3;
  localparam int unsigned RES_WORDS  = (RTF_WIDTH + META_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned REC_WIDTH  = RES_WORDS * DATA_WIDTH;
  localparam int unsigned IDX_WIDTH  = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
  localparam int unsigned RF_WIDTH   = RTF_WIDTH + CYCLE_RANGE + 1;
  localparam int unsigned CF_WIDTH   = 2 * RTF_WIDTH + ADDR_WIDTH;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(RES_WORDS - 1);
  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK = SCC_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRdFifos, StCmp, StWriteback} state_e;

  state_e                  state_q, state_d;
  logic [RF_WIDTH-1:0]     rdata_q;
  logic [CF_WIDTH-1:0]     cdata_q;
  logic [RTF_WIDTH-1:0]    bitmask_q;
  logic [RTF_WIDTH-1:0]    result_q;
  logic [RTF_WIDTH-1:0]    mask_q;
  logic [CYCLE_RANGE-1:0]  cycles_q;
  logic                    timeout_q;
  logic                    fail_q;
  logic [ADDR_WIDTH-1:0]   address_q;
  logic [IDX_WIDTH-1:0]    index_q;

  logic [RTF_WIDTH-1:0]    rf_result;
  logic [CYCLE_RANGE-1:0]  rf_cycles;
  logic                    rf_timeout;
  logic [RTF_WIDTH-1:0]    cf_dont_care;
  logic [RTF_WIDTH-1:0]    cf_expected;
  logic [ADDR_WIDTH-1:0]   cf_base;
  logic [RTF_WIDTH-1:0]    mask_eff;
  logic                    cmp_fail;
  logic [REC_WIDTH-1:0]    record;

  // Words popped in StRdFifos, decoded and compared during StCmp.
  assign rf_result    = rdata_q[RF_WIDTH-1 -: RTF_WIDTH];
  assign rf_cycles    = rdata_q[CYCLE_RANGE:1];
  assign rf_timeout   = rdata_q[0];
  assign cf_dont_care = cdata_q[CF_WIDTH-1 -: RTF_WIDTH];
  assign cf_expected  = cdata_q[ADDR_WIDTH +: RTF_WIDTH];
  assign cf_base      = cdata_q[ADDR_WIDTH-1:0];
  assign mask_eff     = bitmask_q & ~cf_dont_care;
  assign cmp_fail     = (rf_result & mask_eff) != (cf_expected & mask_eff);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (!bus.rfifo_rdempty && !bus.cfifo_rdempty) state_d = StRdFifos;
      StRdFifos:   state_d = StCmp;
      StCmp:       state_d = StWriteback;
      StWriteback: if (!bus.mem_waitrequest && (index_q == LAST_IDX)) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Record: masked result in the MS bits, meta in the LS bits, zero pad between.
  always_comb begin
    record = '0;
    record[REC_WIDTH-1 -: RTF_WIDTH] = result_q & mask_q;
    record[META_WIDTH-1:0]           = {1'b1, timeout_q, cycles_q, fail_q};
  end

  assign bus.mem_write      = (state_q == StWriteback);
  assign bus.mem_address    = address_q;
  assign bus.mem_byteenable = '1;
  assign bus.mem_writedata  = record[(RES_WORDS - 1 - 32'(index_q)) * DATA_WIDTH +: DATA_WIDTH];
  assign bus.rfifo_rdreq    = (state_q == StRdFifos);
  assign bus.cfifo_rdreq    = (state_q == StRdFifos);
  assign bus.sc_ready       = (state_q == StIdle) & bus.rfifo_rdempty & bus.cfifo_rdempty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rdata_q   <= '0;
      cdata_q   <= '0;
      bitmask_q <= '1;
      result_q  <= '0;
      mask_q    <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
      fail_q    <= 1'b0;
      address_q <= '0;
      index_q   <= '0;
    end else begin
      state_q <= state_d;
      if (bus.sc_cmd == CMD_BITMASK) bitmask_q <= bus.sc_data;
      if (state_q == StRdFifos) begin
        rdata_q <= bus.rfifo_data;
        cdata_q <= bus.cfifo_data;
      end
      // Mask is frozen here so later BITMASK commands don't touch the record in flight.
      if (state_q == StCmp) begin
        result_q  <= rf_result;
        mask_q    <= mask_eff;
        cycles_q  <= rf_cycles;
        timeout_q <= rf_timeout;
        fail_q    <= cmp_fail;
        address_q <= cf_base;
        index_q   <= '0;
      end
      if ((state_q == StWriteback) && !bus.mem_waitrequest) begin
        address_q <= address_q + ADDR_WIDTH'(1);
        index_q   <= index_q + IDX_WIDTH'(1);
      end
    end
  end

`ifdef CHECK_STATS_EN
  localparam logic [SCC_WIDTH-1:0] CMD_CLR_STATS = SCC_WIDTH'(2);

  logic [CNT_WIDTH-1:0] pass_count_q, fail_count_q;

  // Saturating counters; a clear beats an increment in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_count_q <= '0;
      fail_count_q <= '0;
    end else if (bus.sc_cmd == CMD_CLR_STATS) begin
      pass_count_q <= '0;
      fail_count_q <= '0;
    end else if (state_q == StCmp) begin
      if (cmp_fail) begin
        if (fail_count_q != '1) fail_count_q <= fail_count_q + CNT_WIDTH'(1);
      end else begin
        if (pass_count_q != '1) pass_count_q <= pass_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign pass_count = pass_count_q;
  assign fail_count = fail_count_q;
`endif

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: FIFO and Avalon slave models, expected records queued at
// push time, a forked monitor checks every write cycle against the queue head.
module tb_result_checker;
  localparam int unsigned AW        = 20;
  localparam int unsigned DW        = 16;
  localparam int unsigned RW        = 24;
  localparam int unsigned CR        = 5;
  localparam int unsigned SW        = 5;
  localparam int unsigned META_W    = CR + 3;
  localparam int unsigned RES_WORDS = (RW + META_W + DW - 1) / DW;
  localparam int unsigned REC_W     = RES_WORDS * DW;
  localparam int unsigned RF_W      = RW + CR + 1;
  localparam int unsigned CF_W      = 2 * RW + AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  result_checker_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RTF_WIDTH(RW), .CYCLE_RANGE(CR), .SCC_WIDTH(SW)
  ) bus ();

`ifdef CHECK_STATS_EN
  logic [15:0] pass_count, fail_count;
`endif

  result_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RTF_WIDTH(RW), .CYCLE_RANGE(CR), .SCC_WIDTH(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef CHECK_STATS_EN
    ,
    .pass_count(pass_count),
    .fail_count(fail_count)
`endif
  );

  exp_t            exp_q[$];
  logic [RF_W-1:0] rq[$];
  logic [CF_W-1:0] cq[$];
  int              n_chk = 0;
  int              n_err = 0;
  logic [RW-1:0]   bitmask_m;
  int              pass_m, fail_m;
  bit              pop_r, pop_c, stall_rand;
  int              stall_force;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    bus.rfifo_rdempty = (rq.size() == 0);
    bus.rfifo_data    = (rq.size() != 0) ? rq[0] : '0;
    bus.cfifo_rdempty = (cq.size() == 0);
    bus.cfifo_data    = (cq.size() != 0) ? cq[0] : '0;
  endtask

  // One clock: pops/stall/command changes just after posedge, rdreq sampled after negedge.
  task automatic step();
    @(posedge clock);
    #1;
    if (pop_r && rq.size() > 0) void'(rq.pop_front());
    if (pop_c && cq.size() > 0) void'(cq.pop_front());
    refresh();
    bus.sc_cmd          = '0;
    bus.mem_waitrequest = 1'b0;
    if (stall_force > 0 && bus.mem_write) begin
      bus.mem_waitrequest = 1'b1;
      stall_force--;
    end else if (stall_rand) begin
      bus.mem_waitrequest = ($urandom_range(0, 2) == 0);
    end
    @(negedge clock);
    #1;
    pop_r = bus.rfifo_rdreq;
    pop_c = bus.cfifo_rdreq;
  endtask

  // Reference model: record = {result & mask, pad, 1, timeout, cycles, fail}, MS word first.
  task automatic push_vec(input logic [RW-1:0] res, input logic [RW-1:0] expv,
                          input logic [RW-1:0] dc, input logic [CR-1:0] cyc,
                          input logic to, input logic [AW-1:0] base);
    logic [RW-1:0]    m;
    logic             f;
    logic [REC_W-1:0] rec;
    exp_t             e;
    m   = bitmask_m & ~dc;
    f   = ((res ^ expv) & m) != '0;
    rec = (REC_W'(res & m) << (REC_W - RW)) | REC_W'({1'b1, to, cyc, f});
    for (int i = 0; i < int'(RES_WORDS); i++) begin
      e.addr = base + AW'(i);
      e.data = DW'(rec >> ((int'(RES_WORDS) - 1 - i) * int'(DW)));
      exp_q.push_back(e);
    end
    if (f) fail_m++;
    else pass_m++;
    rq.push_back({res, cyc, to});
    cq.push_back({dc, expv, base});
    refresh();
  endtask

  task automatic push_rand();
    logic [RW-1:0] r, e, d;
    r = RW'($urandom);
    case ($urandom_range(0, 2))
      0:       e = r;
      1:       e = r ^ (RW'(1) << $urandom_range(0, RW - 1));
      default: e = RW'($urandom);
    endcase
    d = ($urandom_range(0, 1) == 1) ? RW'($urandom) : '0;
    push_vec(r, e, d, CR'($urandom), 1'($urandom), AW'($urandom));
  endtask

  task automatic set_mask(input logic [RW-1:0] m);
    bus.sc_cmd  = SW'(1);
    bus.sc_data = m;
    bitmask_m   = m;
    step();
  endtask

  task automatic wait_empty(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check("drain_records_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_stats();
`ifdef CHECK_STATS_EN
    check("pass_count", 64'(pass_count), 64'(pass_m));
    check("fail_count", 64'(fail_count), 64'(fail_m));
`endif
  endtask

  task automatic drain();
    int n;
    wait_empty(n);
    n = 0;
    while (!bus.sc_ready && n < 20) begin
      step();
      n++;
    end
    check("sc_ready_after_drain", 64'(bus.sc_ready), 64'(1));
    check_stats();
  endtask

  task automatic wait_write();
    int n = 0;
    while (!bus.mem_write && n < 50) begin
      step();
      n++;
    end
    check("write_started", 64'(bus.mem_write), 64'(1));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (!reset && bus.mem_write) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                   bus.mem_address, bus.mem_writedata);
        end else begin
          check("wr_address", 64'(bus.mem_address), 64'(exp_q[0].addr));
          check("wr_data", 64'(bus.mem_writedata), 64'(exp_q[0].data));
          if (!bus.mem_waitrequest) begin
            check("wr_byteenable", 64'(bus.mem_byteenable), 64'(2'b11));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    reset               = 1'b1;
    bus.mem_waitrequest = 1'b0;
    bus.sc_cmd          = '0;
    bus.sc_data         = '0;
    bitmask_m           = '1;
    pass_m              = 0;
    fail_m              = 0;
    stall_force         = 0;
    stall_rand          = 1'b0;
    pop_r               = 1'b0;
    pop_c               = 1'b0;
    refresh();
    fork
      monitor();
    join_none

    // Reset state
    #3;
    check("rst_mem_write", 64'(bus.mem_write), 64'(0));
    check("rst_address", 64'(bus.mem_address), 64'(0));
    check("rst_rdreq", 64'({bus.rfifo_rdreq, bus.cfifo_rdreq}), 64'(0));
    check("rst_sc_ready", 64'(bus.sc_ready), 64'(1));
    check_stats();
    @(negedge clock);
    #1;
    reset = 1'b0;
    step();

    // Default example and minimum latency: A5A5 @100, A586 @101
    push_vec(24'hA5A5A5, 24'hA5A5A5, 24'h0, 5'd3, 1'b0, 20'h00100);
    wait_empty(n);
    check("min_latency", 64'(n), 64'(2 + RES_WORDS));
    drain();

    // Don't-care hides the mismatch, then the same mismatch without it
    push_vec(24'h000001, 24'h000000, 24'h000001, 5'd0, 1'b0, 20'h00200);
    drain();
    push_vec(24'h000001, 24'h000000, 24'h000000, 5'd0, 1'b0, 20'h00210);
    drain();

    // Four waitrequest cycles on word 0
    stall_force = 4;
    push_vec(24'h3C3C3C, 24'h3C3C3D, 24'h0, 5'd17, 1'b1, 20'h00500);
    wait_empty(n);
    check("stall_latency", 64'(n), 64'(2 + RES_WORDS + 4));
    drain();

    // BITMASK during writeback affects only the next vector
    push_vec(24'h123456, 24'h123456, 24'h0, 5'd7, 1'b1, 20'h00300);
    wait_write();
    bus.sc_cmd  = SW'(1);
    bus.sc_data = 24'hFFFF00;
    bitmask_m   = 24'hFFFF00;
    push_vec(24'hABCDEF, 24'hABCD00, 24'h0, 5'd1, 1'b0, 20'h00400);
    drain();
    set_mask('1);

    // Address wrap
    push_vec(24'h5A5A5A, 24'h5A5A5A, 24'h0, 5'd31, 1'b0, 20'hFFFFF);
    drain();

    // Only one FIFO non-empty: no pop, not ready
    rq.push_back({24'h777777, 5'd2, 1'b0});
    refresh();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= bus.rfifo_rdreq | bus.cfifo_rdreq;
    end
    check("rfifo_only_no_pop", 64'(seen), 64'(0));
    check("rfifo_only_not_ready", 64'(bus.sc_ready), 64'(0));
    rq.delete();
    cq.push_back({24'h0, 24'h777777, 20'h00600});
    refresh();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= bus.rfifo_rdreq | bus.cfifo_rdreq;
    end
    check("cfifo_only_no_pop", 64'(seen), 64'(0));
    cq.delete();
    refresh();
    step();

`ifdef CHECK_STATS_EN
    // Counters: clear, 3 pass + 2 fail, clear again
    bus.sc_cmd = SW'(2);
    step();
    pass_m = 0;
    fail_m = 0;
    check_stats();
    for (int i = 0; i < 5; i++)
      push_vec(24'h010203 + RW'(i), (i < 3) ? 24'h010203 + RW'(i) : 24'hFFFFFF, 24'h0,
               CR'(i), 1'b0, 20'h00700 + AW'(4 * i));
    drain();
    check("directed_pass_count", 64'(pass_count), 64'(3));
    check("directed_fail_count", 64'(fail_count), 64'(2));
    bus.sc_cmd = SW'(2);
    step();
    pass_m = 0;
    fail_m = 0;
    check_stats();
`endif

    // Randomised batches with random stalls and masks
    stall_rand = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_mask(($urandom_range(0, 1) == 1) ? '1 : RW'($urandom));
      for (int i = 0; i < 10; i++) begin
        push_rand();
        for (int g = $urandom_range(0, 3); g > 0; g--) step();
      end
      drain();
    end
    stall_rand = 1'b0;
    set_mask('1);

    // Reset in the middle of a record
    stall_force = 2;
    push_vec(24'hCAFE00, 24'hCAFE00, 24'h0, 5'd9, 1'b0, 20'h00800);
    wait_write();
    #1;
    reset = 1'b1;
    #1;
    check("midrst_mem_write", 64'(bus.mem_write), 64'(0));
    check("midrst_address", 64'(bus.mem_address), 64'(0));
    check("midrst_sc_ready", 64'(bus.sc_ready), 64'(1));
    exp_q.delete();
    pass_m      = 0;
    fail_m      = 0;
    bitmask_m   = '1;
    stall_force = 0;
    check_stats();
    step();
    reset = 1'b0;
    step();
    push_vec(24'h0F0F0F, 24'h0F0F0E, 24'h0, 5'd4, 1'b1, 20'h00900);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
